// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the cache-line serializer / deserializer pair.
// Holds the line geometry, the FIFO entry layout and the burst FSM states.
// No ports; imported by cc_deserializer (and by the serializer side).
// ---------------------------------------------------------------------------
package cc_pkg;

    localparam int LINE_W       = 512;
    localparam int BEAT_W       = 64;
    localparam int BEATS        = 8;
    localparam int OFFSET_W     = 6;
    localparam int FIFO_ENTRY_W = OFFSET_W + LINE_W;

    // One cache line as eight 64-bit words; word 0 occupies bits [63:0].
    typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

    // Entry pushed into the line FIFO: byte offset on top, line below.
    typedef struct packed {
        logic [OFFSET_W-1:0] offset;
        line_t               line;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_PUSH
    } state_t;

    // Word index of the critical word; the low three byte bits are ignored.
    function automatic logic [2:0] word_index(input logic [OFFSET_W-1:0] offset);
        return offset[OFFSET_W-1:3];
    endfunction

endpackage

// File: rtl/cc_deserializer.sv
// ---------------------------------------------------------------------------
// cc_deserializer
// Collects an 8-beat, 64-bit critical-word-first wrapping burst into one
// 512-bit cache line and writes it into the line FIFO as {offset, line}.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   start_valid_i    burst descriptor valid
//   start_offset_i   byte offset of the critical word (6 bits)
//   start_ready_o    descriptor accepted when valid & ready
//   rdata_i          beat data (64 bits)
//   rlast_i          last-beat marker from the source (checked, not trusted)
//   rvalid_i         beat valid
//   rready_o         beat accepted when valid & ready
//   fifo_full_i      line FIFO full
//   fifo_wren_o      line FIFO write strobe
//   fifo_wdata_o     {offset[5:0], line[511:0]}
//   err_o            one-cycle pulse when rlast_i disagrees with the beat count
// ---------------------------------------------------------------------------
module cc_deserializer #(
    parameter int DATA_W   = 64,
    parameter int BEATS    = 8,
    parameter int OFFSET_W = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_valid_i,
    input  logic [OFFSET_W-1:0]            start_offset_i,
    output logic                           start_ready_o,
    input  logic [DATA_W-1:0]              rdata_i,
    input  logic                           rlast_i,
    input  logic                           rvalid_i,
    output logic                           rready_o,
    input  logic                           fifo_full_i,
    output logic                           fifo_wren_o,
    output logic [cc_pkg::FIFO_ENTRY_W-1:0] fifo_wdata_o,
    output logic                           err_o
);

    import cc_pkg::*;

    // The line layout and FIFO entry are fixed in the package; any other
    // geometry would silently mis-pack the entry, so refuse to elaborate.
    if (DATA_W != BEAT_W || BEATS != cc_pkg::BEATS || OFFSET_W != cc_pkg::OFFSET_W) begin : g_bad_param
        $error("cc_deserializer: only DATA_W=64, BEATS=8, OFFSET_W=6 are supported");
    end

    state_t                      state;
    state_t                      state_next;
    logic [2:0]                  cnt;
    logic [2:0]                  wptr;
    logic [cc_pkg::OFFSET_W-1:0] offset_q;
    line_t                       line_q;
    fifo_entry_t                 entry;

    logic start_fire;
    logic beat_fire;
    logic last_beat;

    assign start_fire = (state == S_IDLE) && start_valid_i;
    assign beat_fire  = (state == S_COLLECT) && rvalid_i;
    assign last_beat  = (cnt == 3'd7);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Beat counting alone ends the burst; rlast_i is only
    // checked, so a misbehaving source cannot shorten or lengthen a line.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_valid_i) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (rvalid_i && last_beat) begin
                    state_next = S_PUSH;
                end
            end
            S_PUSH: begin
                if (!fifo_full_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic. The combinational outputs are forced to their reset
    // values while rst_n is low so nothing leaks out in the reset cycle
    // itself, before the synchronous reset has taken effect.
    always_comb begin
        start_ready_o = 1'b1;
        rready_o      = 1'b0;
        fifo_wren_o   = 1'b0;
        err_o         = 1'b0;
        if (rst_n) begin
            start_ready_o = (state == S_IDLE);
            rready_o      = (state == S_COLLECT);
            fifo_wren_o   = (state == S_PUSH) && !fifo_full_i;
            err_o         = beat_fire && (rlast_i != last_beat);
        end
    end

    // Line assembly. The write pointer starts at the critical word and wraps
    // through all eight slots, so every word of the line is overwritten by
    // each burst and a discarded partial line never needs clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            wptr     <= '0;
            offset_q <= '0;
            line_q   <= '0;
        end else begin
            if (start_fire) begin
                offset_q <= start_offset_i;
                wptr     <= word_index(start_offset_i);
                cnt      <= '0;
            end
            if (beat_fire) begin
                line_q[wptr] <= rdata_i;
                wptr         <= wptr + 3'd1;
                cnt          <= cnt + 3'd1;
            end
        end
    end

    always_comb begin
        entry.offset = offset_q;
        entry.line   = line_q;
    end

    assign fifo_wdata_o = entry;

endmodule

// File: tb/tb_cc_deserializer.sv
// ---------------------------------------------------------------------------
// tb_cc_deserializer
// Directed bench for cc_deserializer. Inputs change 1 time unit after the
// rising edge and outputs are compared on the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_cc_deserializer;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic [5:0]   start_offset;
    logic         start_ready;
    logic [63:0]  rdata;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         fifo_full;
    logic         fifo_wren;
    logic [517:0] fifo_wdata;
    logic         err;

    int checks;
    int failures;

    cc_deserializer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_valid_i  (start_valid),
        .start_offset_i (start_offset),
        .start_ready_o  (start_ready),
        .rdata_i        (rdata),
        .rlast_i        (rlast),
        .rvalid_i       (rvalid),
        .rready_o       (rready),
        .fifo_full_i    (fifo_full),
        .fifo_wren_o    (fifo_wren),
        .fifo_wdata_o   (fifo_wdata),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle worth of inputs and wait until the outputs are settled.
    task automatic applyStimulus(input logic rst, input logic sv, input logic [5:0] soff,
                                 input logic [63:0] rd, input logic rl, input logic rv,
                                 input logic ff);
        @(posedge clk);
        #1;
        rst_n        = rst;
        start_valid  = sv;
        start_offset = soff;
        rdata        = rd;
        rlast        = rl;
        rvalid       = rv;
        fifo_full    = ff;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [517:0] observed,
                               input logic [517:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    localparam logic [517:0] EXP_ALIGNED = {6'h00,
        64'h1007, 64'h1006, 64'h1005, 64'h1004, 64'h1003, 64'h1002, 64'h1001, 64'h1000};
    localparam logic [517:0] EXP_WRAP = {6'h2C,
        64'hA2, 64'hA1, 64'hA0, 64'hA7, 64'hA6, 64'hA5, 64'hA4, 64'hA3};
    localparam logic [517:0] EXP_STALL = {6'h08,
        64'hB6, 64'hB5, 64'hB4, 64'hB3, 64'hB2, 64'hB1, 64'hB0, 64'hB7};
    localparam logic [517:0] EXP_ERR = {6'h00,
        64'hC7, 64'hC6, 64'hC5, 64'hC4, 64'hC3, 64'hC2, 64'hC1, 64'hC0};
    localparam logic [517:0] EXP_B2B_A = {6'h00,
        64'hD7, 64'hD6, 64'hD5, 64'hD4, 64'hD3, 64'hD2, 64'hD1, 64'hD0};
    localparam logic [517:0] EXP_B2B_B = {6'h38,
        64'hE0, 64'hE7, 64'hE6, 64'hE5, 64'hE4, 64'hE3, 64'hE2, 64'hE1};
    localparam logic [517:0] EXP_RESTART = {6'h10,
        64'h55, 64'h54, 64'h53, 64'h52, 64'h51, 64'h50, 64'h57, 64'h56};

    initial begin
        logic [63:0] rd;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        start_offset = '0;
        rdata        = '0;
        rlast        = 1'b0;
        rvalid       = 1'b0;
        fifo_full    = 1'b0;

        // Reset state.
        applyStimulus(0, 0, 6'h00, 64'h0, 0, 0, 0);
        applyStimulus(0, 0, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("rst_start_ready", start_ready, 1);
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_wren", fifo_wren, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_wdata", fifo_wdata, 0);

        // Aligned burst at offset 0.
        applyStimulus(1, 1, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("al_start_ready", start_ready, 1);
        checkOutput("al_idle_rready", rready, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 6'h00, 64'h1000 + 64'(k), k == 7, 1, 0);
            checkOutput("al_beat_rready", rready, 1);
            checkOutput("al_beat_err", err, 0);
            checkOutput("al_beat_wren", fifo_wren, 0);
        end
        applyStimulus(1, 0, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("al_push_wren", fifo_wren, 1);
        checkOutput("al_push_start_ready", start_ready, 0);
        checkOutput("al_push_wdata", fifo_wdata, EXP_ALIGNED);

        // Wrapped burst starting at word 5.
        applyStimulus(1, 1, 6'h2C, 64'h0, 0, 0, 0);
        checkOutput("wr_start_ready", start_ready, 1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 6'h00, 64'hA0 + 64'(k), k == 7, 1, 0);
            checkOutput("wr_beat_err", err, 0);
        end
        applyStimulus(1, 0, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("wr_push_wren", fifo_wren, 1);
        checkOutput("wr_push_wdata", fifo_wdata, EXP_WRAP);

        // Stalled beats and a full FIFO.
        applyStimulus(1, 1, 6'h08, 64'h0, 0, 0, 0);
        checkOutput("st_start_ready", start_ready, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 6'h00, 64'hB0 + 64'(k), 0, 1, 0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 6'h00, 64'hDEAD, 1, 0, 0);
            checkOutput("st_stall_rready", rready, 1);
            checkOutput("st_stall_wren", fifo_wren, 0);
            checkOutput("st_stall_err", err, 0);
        end
        for (int k = 3; k < 8; k++) begin
            applyStimulus(1, 0, 6'h00, 64'hB0 + 64'(k), k == 7, 1, 0);
            checkOutput("st_beat_err", err, 0);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 6'h00, 64'h0, 0, 0, 1);
            checkOutput("st_full_wren", fifo_wren, 0);
            checkOutput("st_full_rready", rready, 0);
            checkOutput("st_full_wdata", fifo_wdata, EXP_STALL);
        end
        applyStimulus(1, 0, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("st_push_wren", fifo_wren, 1);
        checkOutput("st_push_wdata", fifo_wdata, EXP_STALL);
        applyStimulus(1, 0, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("st_after_wren", fifo_wren, 0);
        checkOutput("st_after_start_ready", start_ready, 1);

        // rlast early on beat 5 and missing on beat 7.
        applyStimulus(1, 1, 6'h00, 64'h0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 6'h00, 64'hC0 + 64'(k), k == 5, 1, 0);
            checkOutput($sformatf("er_beat%0d_err", k), err, (k == 5 || k == 7) ? 1 : 0);
        end
        applyStimulus(1, 0, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("er_push_wren", fifo_wren, 1);
        checkOutput("er_push_err", err, 0);
        checkOutput("er_push_wdata", fifo_wdata, EXP_ERR);

        // Back-to-back bursts with descriptor and beats held valid.
        for (int c = 0; c < 21; c++) begin
            rd = 64'h0;
            if (c >= 1 && c <= 8) rd = 64'hD0 + 64'(c - 1);
            if (c >= 11 && c <= 18) rd = 64'hE0 + 64'(c - 11);
            applyStimulus(1, c <= 10, (c < 10) ? 6'h00 : 6'h38, rd, c == 8 || c == 18, 1, 0);
            checkOutput($sformatf("bb_c%0d_start_ready", c), start_ready, (c == 0 || c == 10 || c == 20) ? 1 : 0);
            checkOutput($sformatf("bb_c%0d_wren", c), fifo_wren, (c == 9 || c == 19) ? 1 : 0);
            checkOutput($sformatf("bb_c%0d_err", c), err, 0);
            if (c == 9) checkOutput("bb_first_wdata", fifo_wdata, EXP_B2B_A);
            if (c == 19) checkOutput("bb_second_wdata", fifo_wdata, EXP_B2B_B);
        end

        // Reset after four beats, then a fresh burst at offset 0x10.
        applyStimulus(1, 1, 6'h00, 64'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 6'h00, 64'hF0 + 64'(k), 0, 1, 0);
        end
        applyStimulus(0, 0, 6'h00, 64'hFF, 1, 1, 0);
        checkOutput("rs_during_start_ready", start_ready, 1);
        checkOutput("rs_during_rready", rready, 0);
        checkOutput("rs_during_wren", fifo_wren, 0);
        checkOutput("rs_during_err", err, 0);
        applyStimulus(1, 1, 6'h10, 64'h0, 0, 0, 0);
        checkOutput("rs_after_start_ready", start_ready, 1);
        checkOutput("rs_after_wdata", fifo_wdata, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 6'h00, 64'h50 + 64'(k), k == 7, 1, 0);
            checkOutput("rs_beat_wren", fifo_wren, 0);
            checkOutput("rs_beat_err", err, 0);
        end
        applyStimulus(1, 0, 6'h00, 64'h0, 0, 0, 0);
        checkOutput("rs_push_wren", fifo_wren, 1);
        checkOutput("rs_push_wdata", fifo_wdata, EXP_RESTART);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_deserializer.md
Name: cc_deserializer

Overview:
- Fill-path counterpart of the line serializer: accepts an 8-beat, 64-bit burst, assembles one 512-bit cache line and pushes it into the line FIFO as a 518-bit entry {offset[5:0], line[511:0]}.
- Bursts arrive critical-word-first and wrap. Beat k is placed at word index (offset[5:3] + k) mod 8.
- Sits between the memory-side read channel and the line FIFO that feeds the cache fill logic.

Parameters:
- DATA_W, 64, beat width in bits.
- BEATS, 8, beats per line; line width is DATA_W*BEATS = 512.
- OFFSET_W, 6, byte-offset width; word index = offset[OFFSET_W-1:3].
- Only the defaults are supported; an elaboration-time check flags any other value.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- start_valid_i  input  1  burst descriptor valid
- start_offset_i  input  6  byte offset of the critical word
- start_ready_o  output  1  descriptor accepted when valid&ready
- rdata_i  input  64  beat data
- rlast_i  input  1  last-beat marker from the source
- rvalid_i  input  1  beat valid
- rready_o  output  1  beat accepted when valid&ready
- fifo_full_i  input  1  line FIFO full
- fifo_wren_o  output  1  line FIFO write strobe
- fifo_wdata_o  output  518  {offset[5:0], line[511:0]}
- err_o  output  1  one-cycle pulse on an rlast protocol mismatch

Behaviour:
- States:
  - S_IDLE: start_ready_o=1, rready_o=0. On start_valid_i, latch start_offset_i, set wptr=start_offset_i[5:3], clear cnt, go to S_COLLECT.
  - S_COLLECT: start_ready_o=0, rready_o=1. On rvalid_i:
    - line[wptr] <= rdata_i
    - wptr <= wptr+1 (3-bit, wraps 7->0)
    - cnt <= cnt+1
    - when cnt==7, go to S_PUSH.
  - S_PUSH: start_ready_o=0, rready_o=0. fifo_wren_o = !fifo_full_i; fifo_wdata_o = {offset_q, line_q}. When fifo_wren_o=1, go to S_IDLE.
- Outputs:
  - fifo_wdata_o is driven from registers in every state; it is only meaningful while fifo_wren_o=1.
  - fifo_wren_o is combinational from state and fifo_full_i; it never depends on rvalid_i.
- Latency: the FIFO write occurs at the earliest in the cycle after the 8th beat handshake. The next descriptor can be accepted the cycle after the write.
- Minimum burst period is 10 cycles (1 descriptor + 8 beats + 1 push).
- Backpressure:
  - rvalid_i low in S_COLLECT stalls the burst with no state change.
  - fifo_full_i high in S_PUSH holds the state indefinitely; line and offset registers are stable.
- rlast check, on each accepted beat:
  - err_o=1 if rlast_i != (cnt==7), in the same cycle as the beat.
  - Beat counting ignores rlast_i; exactly 8 beats are always consumed.
- Offset: the full 6-bit offset is stored unchanged, low 3 bits included. Only [5:3] steer placement.
- Boundaries:
  - offset 0 fills in order 0..7.
  - offset 0x38 fills 7,0,1,...,6.
  - cnt is 3-bit and wraps 7->0 on the transition to S_PUSH.
- Reset (rst_n=0 at any clock edge, including mid-burst or mid-push):
  - state=S_IDLE; cnt=0, wptr=0, offset_q=0, line_q=0.
  - Outputs: start_ready_o=1, rready_o=0, fifo_wren_o=0, err_o=0, fifo_wdata_o=0.
  - A partially assembled line is discarded.

Decomposition:
- Shared package cc_pkg holds:
  - LINE_W=512, BEAT_W=64, BEATS=8, OFFSET_W=6, FIFO_ENTRY_W=518
  - typedef line_t as logic [7:0][63:0]
  - typedef fifo_entry_t as struct {offset, line}
  - the state enum
- The serializer side uses the same package.
- No sub-module; the 8x64 line register with its write pointer is inline.

Test Plan:
- Aligned burst: offset 0x00, beats 0x1000+k (k=0..7), FIFO not full -> one fifo_wren_o pulse; word i = 0x1000+i; wdata[517:512]=0x00; err_o never asserted.
- Wrapped burst: offset 0x2C, beats 0xA0+k -> words 5,6,7,0,1,2,3,4 = 0xA0..0xA7; i.e. word5=0xA0, word4=0xA7; wdata[517:512]=0x2C.
- Stall: rvalid_i deasserted 3 cycles after beat 2 and fifo_full_i high for 5 cycles in S_PUSH -> rready_o stays 1 during the stall; fifo_wren_o=0 for 5 cycles, then a single pulse; data intact.
- Protocol error: rlast_i on beat 5 and not on beat 7 -> err_o pulses on beats 5 and 7; line still written after 8 beats.
- Back-to-back: two descriptors (0x00, 0x38) held valid continuously with continuous beats -> second start_ready_o handshake is exactly 1 cycle after the first fifo_wren_o; two FIFO writes 10 cycles apart.
- Reset mid-burst: rst_n low after beat 4 for 1 cycle, then a fresh offset-0x10 burst -> no write for the aborted burst; the new line holds only new data; all outputs at reset values during reset.
